// File: rtl/hbm_bringup_seq.sv
// hbm_bringup_seq: multi-channel HBM bring-up and health sequencer.
// Orders the IOPLL, NoC and AXI reset releases. Waits for a stable PLL lock and then for
// per-channel calibration, with a timeout and a bounded number of retries. Once running,
// it supervises lock loss and catastrophic trips and latches faults.
//
// Ports:
//   clk100_in_clk            sole clock
//   sys_reset_in_reset       synchronous active-high reset
//   iopll_locked_export      IOPLL lock indication
//   hbm_fp_cattrip_i_conduit per-channel catastrophic trip
//   hbm_fp_temp_i_conduit    per-channel 3-bit temperature code, channel i at [3i+2:3i]
//   hbm_local_cal_success    per-channel calibration success
//   hbm_local_cal_fail       per-channel calibration fail
//   iopll_reset_reset        IOPLL reset request (PLL_RST, FAULT)
//   noc_reset_out_reset      NoC reset (low from NOC_REL through RUN)
//   axi_reset_out_reset      AXI user reset (low only in RUN)
//   hbm_ready / hbm_fault    in RUN / in FAULT
//   seq_state                current state code
//   retry_cnt                retries used
//   err_flags                sticky {cattrip, lock_lost, wait_timeout, cal_fail}
//   throttle                 per-channel over-temperature throttle with hysteresis
//   max_temp                 highest temperature code seen since reset
module hbm_bringup_seq #(
    parameter int unsigned NUM_CH           = 2,
    parameter int unsigned PLL_RST_CYC      = 8,
    parameter int unsigned LOCK_STABLE_CYC  = 16,
    parameter int unsigned NOC_DLY_CYC      = 4,
    parameter int unsigned WAIT_TIMEOUT_CYC = 65536,
    parameter int unsigned MAX_RETRY        = 2,
    parameter int unsigned TEMP_HOT         = 5
) (
    input  logic                  clk100_in_clk,
    input  logic                  sys_reset_in_reset,
    input  logic                  iopll_locked_export,
    input  logic [NUM_CH-1:0]     hbm_fp_cattrip_i_conduit,
    input  logic [3*NUM_CH-1:0]   hbm_fp_temp_i_conduit,
    input  logic [NUM_CH-1:0]     hbm_local_cal_success,
    input  logic [NUM_CH-1:0]     hbm_local_cal_fail,
    output logic                  iopll_reset_reset,
    output logic                  noc_reset_out_reset,
    output logic                  axi_reset_out_reset,
    output logic                  hbm_ready,
    output logic                  hbm_fault,
    output logic [2:0]            seq_state,
    output logic [1:0]            retry_cnt,
    output logic [3:0]            err_flags,
    output logic [NUM_CH-1:0]     throttle,
    output logic [2:0]            max_temp
);

    localparam int unsigned MaxA   = (PLL_RST_CYC > NOC_DLY_CYC) ? PLL_RST_CYC : NOC_DLY_CYC;
    localparam int unsigned MaxB   = (WAIT_TIMEOUT_CYC > LOCK_STABLE_CYC) ?
                                     WAIT_TIMEOUT_CYC : LOCK_STABLE_CYC;
    localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam int unsigned StbW   = $clog2(LOCK_STABLE_CYC + 1);

    // The down-counter holds "cycles left after this one", so load N-1 for an N-cycle stay.
    localparam logic [CntW-1:0] PllLoad = CntW'((PLL_RST_CYC > 1) ? PLL_RST_CYC - 1 : 0);
    localparam logic [CntW-1:0] NocLoad = CntW'((NOC_DLY_CYC > 1) ? NOC_DLY_CYC - 1 : 0);
    localparam logic [CntW-1:0] TmoLoad =
        CntW'((WAIT_TIMEOUT_CYC > 1) ? WAIT_TIMEOUT_CYC - 1 : 0);
    localparam logic [StbW-1:0] StableTgt = StbW'(LOCK_STABLE_CYC);
    localparam logic [1:0]      MaxRetry  = 2'(MAX_RETRY);
    localparam logic [2:0]      HotCode   = 3'(TEMP_HOT);

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StNocRel   = 3'd2,
        StWaitCal  = 3'd3,
        StAxiRel   = 3'd4,
        StRun      = 3'd5,
        StFault    = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [StbW-1:0]     stable_q, stable_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [1:0]          retry_q, retry_d;
    logic [3:0]          err_q, err_d;
    logic [NUM_CH-1:0]   thr_q, thr_d;
    logic [2:0]          max_q, max_d;
    logic                retry_req;
    logic [3:0]          retry_cause;
    logic [2:0]          temp_ch;

    function automatic logic [CntW-1:0] load_for(state_e s);
        case (s)
            StPllRst:              return PllLoad;
            StWaitLock, StWaitCal: return TmoLoad;
            StNocRel:              return NocLoad;
            default:               return '0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        err_d       = err_q;
        stable_d    = '0;
        mask_d      = '0;
        retry_req   = 1'b0;
        retry_cause = 4'b0000;

        unique case (state_q)
            StPllRst: begin
                if (cnt_q == '0) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (iopll_locked_export) begin
                    stable_d = (stable_q == StableTgt) ? stable_q : stable_q + StbW'(1);
                end
                if (stable_d == StableTgt) begin
                    state_d = StNocRel;
                end else if (cnt_q == '0) begin
                    retry_req   = 1'b1;
                    retry_cause = 4'b0010;
                end
            end
            StNocRel: begin
                if (cnt_q == '0) state_d = StWaitCal;
            end
            StWaitCal: begin
                mask_d = mask_q | hbm_local_cal_success;
                // A fail beats a mask that completes in the same cycle.
                if (|hbm_local_cal_fail) begin
                    retry_req   = 1'b1;
                    retry_cause = 4'b0001;
                end else if (&mask_d) begin
                    state_d = StAxiRel;
                end else if (cnt_q == '0) begin
                    retry_req   = 1'b1;
                    retry_cause = 4'b0010;
                end
            end
            StAxiRel: state_d = StRun;
            StRun: begin
                if (!iopll_locked_export) begin
                    retry_req   = 1'b1;
                    retry_cause = 4'b0100;
                end
            end
            StFault: ;
            default: state_d = StFault;
        endcase

        if (retry_req) begin
            err_d = err_q | retry_cause;
            if (retry_q < MaxRetry) begin
                retry_d = retry_q + 2'd1;
                state_d = StPllRst;
            end else begin
                state_d = StFault;
            end
        end

        // Cattrip overrides any same-cycle retry or progress, including its flag and count.
        if ((|hbm_fp_cattrip_i_conduit) && (state_q != StFault)) begin
            state_d = StFault;
            retry_d = retry_q;
            err_d   = err_q | 4'b1000;
        end
    end

    always_comb begin
        if (state_d != state_q) begin
            cnt_d = load_for(state_d);
        end else begin
            cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CntW'(1);
        end
    end

    always_comb begin
        thr_d   = thr_q;
        max_d   = max_q;
        temp_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            temp_ch = hbm_fp_temp_i_conduit[3*i +: 3];
            if (temp_ch >= HotCode) begin
                thr_d[i] = 1'b1;
            end else if ((HotCode >= 3'd2) && (temp_ch <= HotCode - 3'd2)) begin
                thr_d[i] = 1'b0;
            end
            if (temp_ch > max_d) max_d = temp_ch;
        end
    end

    always_ff @(posedge clk100_in_clk) begin
        if (sys_reset_in_reset) begin
            state_q             <= StPllRst;
            // Reset is an entry into PLL_RST, so the counter starts at its full hold time.
            cnt_q               <= PllLoad;
            stable_q            <= '0;
            mask_q              <= '0;
            retry_q             <= '0;
            err_q               <= '0;
            thr_q               <= '0;
            max_q               <= '0;
            iopll_reset_reset   <= 1'b1;
            noc_reset_out_reset <= 1'b1;
            axi_reset_out_reset <= 1'b1;
            hbm_ready           <= 1'b0;
            hbm_fault           <= 1'b0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            stable_q            <= stable_d;
            mask_q              <= mask_d;
            retry_q             <= retry_d;
            err_q               <= err_d;
            thr_q               <= thr_d;
            max_q               <= max_d;
            iopll_reset_reset   <= (state_d == StPllRst) || (state_d == StFault);
            noc_reset_out_reset <= !(state_d inside {StNocRel, StWaitCal, StAxiRel, StRun});
            axi_reset_out_reset <= (state_d != StRun);
            hbm_ready           <= (state_d == StRun);
            hbm_fault           <= (state_d == StFault);
        end
    end

    assign seq_state = state_q;
    assign retry_cnt = retry_q;
    assign err_flags = err_q;
    assign throttle  = thr_q;
    assign max_temp  = max_q;

endmodule

// File: tb/tb_hbm_bringup_seq.sv
// Bench for hbm_bringup_seq: directed bring-up scenarios with literal expectations, then
// randomized stimulus, all checked every cycle against a phase/elapsed-time model.
module tb_hbm_bringup_seq;

    localparam int NCH  = 2;
    localparam int PLL  = 8;
    localparam int STB  = 16;
    localparam int NOC  = 4;
    localparam int TMO  = 40;
    localparam int MAXR = 2;
    localparam int HOT  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, lock;
    logic [NCH-1:0]   cat, succ, fail;
    logic [3*NCH-1:0] temp;
    logic             iopll, noc_rst, axi_rst, ready, fault;
    logic [2:0]       st;
    logic [1:0]       rcnt;
    logic [3:0]       errf;
    logic [NCH-1:0]   thr;
    logic [2:0]       mt;

    hbm_bringup_seq #(
        .NUM_CH          (NCH),
        .PLL_RST_CYC     (PLL),
        .LOCK_STABLE_CYC (STB),
        .NOC_DLY_CYC     (NOC),
        .WAIT_TIMEOUT_CYC(TMO),
        .MAX_RETRY       (MAXR),
        .TEMP_HOT        (HOT)
    ) dut (
        .clk100_in_clk           (clk),
        .sys_reset_in_reset      (rst),
        .iopll_locked_export     (lock),
        .hbm_fp_cattrip_i_conduit(cat),
        .hbm_fp_temp_i_conduit   (temp),
        .hbm_local_cal_success   (succ),
        .hbm_local_cal_fail      (fail),
        .iopll_reset_reset       (iopll),
        .noc_reset_out_reset     (noc_rst),
        .axi_reset_out_reset     (axi_rst),
        .hbm_ready               (ready),
        .hbm_fault               (fault),
        .seq_state               (st),
        .retry_cnt               (rcnt),
        .err_flags               (errf),
        .throttle                (thr),
        .max_temp                (mt)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: phase code plus cycles already spent in that phase.
    int           m_phase, m_elapsed, m_stable, m_retry, m_max;
    logic [NCH-1:0] m_mask, m_thr;
    logic [3:0]   m_err;

    task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: dut=0x%0h expected=0x%0h t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        cmp(nm, a, e);
    endtask

    task automatic model_step();
        int nxt;
        int t;
        bit rq;
        logic [3:0] cause;
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_stable = 0; m_retry = 0; m_max = 0;
            m_mask = '0; m_thr = '0; m_err = '0;
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            t = int'(temp[3*c +: 3]);
            if (t >= HOT) m_thr[c] = 1'b1;
            else if (t <= HOT - 2) m_thr[c] = 1'b0;
            if (t > m_max) m_max = t;
        end
        nxt = m_phase; rq = 1'b0; cause = 4'b0000;
        case (m_phase)
            0: if (m_elapsed + 1 >= PLL) nxt = 1;
            1: begin
                m_stable = lock ? m_stable + 1 : 0;
                if (m_stable >= STB) nxt = 2;
                else if (m_elapsed + 1 >= TMO) begin rq = 1'b1; cause = 4'b0010; end
            end
            2: if (m_elapsed + 1 >= NOC) nxt = 3;
            3: begin
                m_mask = m_mask | succ;
                if (fail != '0) begin rq = 1'b1; cause = 4'b0001; end
                else if (m_mask == {NCH{1'b1}}) nxt = 4;
                else if (m_elapsed + 1 >= TMO) begin rq = 1'b1; cause = 4'b0010; end
            end
            4: nxt = 5;
            5: if (!lock) begin rq = 1'b1; cause = 4'b0100; end
            default: ;
        endcase
        if (cat != '0 && m_phase != 6) begin
            nxt = 6;
            m_err = m_err | 4'b1000;
        end else if (rq) begin
            m_err = m_err | cause;
            if (m_retry < MAXR) begin
                m_retry++;
                nxt = 0;
            end else begin
                nxt = 6;
            end
        end
        if (nxt != m_phase) begin
            m_elapsed = 0; m_stable = 0; m_mask = '0;
        end else begin
            m_elapsed++;
        end
        m_phase = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int maxc, input string nm);
        int n = 0;
        while (st !== s && n < maxc) begin
            tick();
            n++;
        end
        lit(nm, 32'(st == s), 32'd1);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            cmp("seq_state", 32'(st), 32'(m_phase));
            cmp("iopll_reset", 32'(iopll), 32'(m_phase == 0 || m_phase == 6));
            cmp("noc_reset", 32'(noc_rst), 32'(!(m_phase >= 2 && m_phase <= 5)));
            cmp("axi_reset", 32'(axi_rst), 32'(m_phase != 5));
            cmp("hbm_ready", 32'(ready), 32'(m_phase == 5));
            cmp("hbm_fault", 32'(fault), 32'(m_phase == 6));
            cmp("retry_cnt", 32'(rcnt), 32'(m_retry));
            cmp("err_flags", 32'(errf), 32'(m_err));
            cmp("throttle", 32'(thr), 32'(m_thr));
            cmp("max_temp", 32'(mt), 32'(m_max));
        end
    end

    initial begin
        int n, rdy_k, entries, fc, r;
        logic [2:0] prev;
        rst = 1'b1; lock = 1'b0; cat = '0; succ = '0; fail = '0; temp = '0;
        repeat (2) tick();
        chk_en = 1'b1;

        lit("rst_state", 32'(st), 32'd0);
        lit("rst_iopll", 32'(iopll), 32'd1);
        lit("rst_noc", 32'(noc_rst), 32'd1);
        lit("rst_axi", 32'(axi_rst), 32'd1);
        lit("rst_ready", 32'(ready), 32'd0);
        lit("rst_err", 32'(errf), 32'd0);

        // Clean bring-up: ready exactly 30 edges after the last reset edge.
        lock = 1'b1; succ = 2'b11;
        do_reset();
        n = 0;
        while (!ready && n < 200) begin tick(); n++; end
        lit("bringup_cycles", 32'(n), 32'd30);
        lit("bringup_axi", 32'(axi_rst), 32'd0);
        lit("bringup_retry", 32'(rcnt), 32'd0);
        lit("bringup_err", 32'(errf), 32'd0);

        // Staggered calibration pulses.
        succ = '0;
        do_reset();
        wait_state(3'd3, 100, "stagger_reach_cal");
        rdy_k = -1;
        for (int k = 0; k < 20; k++) begin
            succ = (k == 3) ? 2'b01 : (k == 10) ? 2'b10 : 2'b00;
            tick();
            if (ready && rdy_k < 0) rdy_k = k;
        end
        succ = '0;
        lit("stagger_ready_k", 32'(rdy_k), 32'd11);

        // Calibration fail on every attempt.
        succ = 2'b01; fail = 2'b10;
        do_reset();
        entries = 0; n = 0; prev = st;
        while (!fault && n < 500) begin
            tick();
            n++;
            if (st == 3'd3 && prev != 3'd3) entries++;
            prev = st;
        end
        fail = '0; succ = '0;
        lit("calfail_attempts", 32'(entries), 32'd3);
        lit("calfail_state", 32'(st), 32'd6);
        lit("calfail_retry", 32'(rcnt), 32'd2);
        lit("calfail_err", 32'(errf), 32'b0001);
        lit("calfail_resets", 32'({iopll, noc_rst, axi_rst}), 32'b111);

        // Lock drop in RUN.
        succ = 2'b11;
        do_reset();
        wait_state(3'd5, 100, "lockdrop_run1");
        lock = 1'b0;
        tick();
        lock = 1'b1;
        lit("lockdrop_state", 32'(st), 32'd0);
        lit("lockdrop_iopll", 32'(iopll), 32'd1);
        lit("lockdrop_retry", 32'(rcnt), 32'd1);
        lit("lockdrop_err", 32'(errf), 32'b0100);
        wait_state(3'd5, 100, "lockdrop_run2");

        // Cattrip coincident with cal fail in WAIT_CAL.
        succ = '0;
        do_reset();
        wait_state(3'd3, 100, "cattrip_reach_cal");
        tick(); tick();
        cat = 2'b01; fail = 2'b01;
        tick();
        cat = '0; fail = '0;
        lit("cattrip_state", 32'(st), 32'd6);
        lit("cattrip_err", 32'(errf), 32'b1000);
        lit("cattrip_retry", 32'(rcnt), 32'd0);
        tick();
        lit("cattrip_absorb", 32'(st), 32'd6);

        // Temperature hysteresis on channel 1.
        do_reset();
        temp = {3'd4, 3'd0}; tick(); lit("thr_t4", 32'(thr), 32'b00);
        temp = {3'd5, 3'd0}; tick(); lit("thr_t5", 32'(thr), 32'b10);
        temp = {3'd4, 3'd0}; tick(); lit("thr_t4b", 32'(thr), 32'b10);
        temp = {3'd3, 3'd0}; tick(); lit("thr_t3", 32'(thr), 32'b00);
        lit("max_temp5", 32'(mt), 32'd5);

        // Randomized run; alternating windows starve channel 1 to force timeouts.
        fc = 0;
        for (int i = 0; i < 4000; i++) begin
            fc = fault ? fc + 1 : 0;
            rst  = (fc > 20) || ($urandom_range(0, 799) == 0);
            lock = ($urandom_range(0, 99) != 0);
            r = $urandom;
            cat = '0;
            if ($urandom_range(0, 999) == 0) begin
                cat = r[NCH-1:0];
                if (cat == '0) cat[0] = 1'b1;
            end
            for (int c = 0; c < NCH; c++) begin
                succ[c] = ($urandom_range(0, 3) == 0) && !(((i / 500) % 2 == 1) && c == NCH - 1);
                fail[c] = ($urandom_range(0, 149) == 0);
            end
            if ($urandom_range(0, 7) == 0) temp = r[3*NCH+7:8];
            tick();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
